dma_xfer_ctrl: RTL and testbench

Single-channel DMA transfer sequencer that drives the 10-bit up/down transfer counter.
- Loads a programmed transfer length into the counter.
- Grants one transfer beat per requester handshake (dreq/dack), decrementing the counter once per beat.
- Signals completion, or abort, with a done pulse and a sticky interrupt.
- Sits between the channel register block and the counter instance inside the DMA channel.

---
 rtl/dma_xfer_ctrl.sv | 106 ++++++++++
 tb/tb_dma_xfer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA transfer sequencer: loads the transfer counter, grants one
// beat per dreq/dack handshake and reports completion or abort via done/irq.
module dma_xfer_ctrl #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             nMR,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_len,
    input  logic             abort,
    input  logic             dreq,
    output logic             dack,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_load,
    output logic             cnt_dir,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             irq,
    input  logic             irq_clr
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_REQ,
        ACK,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] len_q;
    logic             ld_len;
    logic             set_abort;
    logic             clr_abort;

    always_ff @(posedge clk or negedge nMR) begin
        if (!nMR) begin
            state_q <= IDLE;
            len_q   <= '0;
            aborted <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_len) begin
                len_q <= cfg_len;
            end
            if (set_abort) begin
                aborted <= 1'b1;
            end else if (clr_abort) begin
                aborted <= 1'b0;
            end
            // A completion in the same cycle as irq_clr must not be lost.
            if (state_q == DONE) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_len    = 1'b0;
        set_abort = 1'b0;
        clr_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_abort = 1'b1;
                    if (cfg_len != '0) begin
                        ld_len  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: state_d = WAIT_REQ;
            WAIT_REQ: begin
                if (abort) begin
                    set_abort = 1'b1;
                    state_d   = DONE;
                end else if (dreq) begin
                    state_d = ACK;
                end
            end
            // The counter still shows the pre-decrement value here, so 1 means last beat.
            ACK: state_d = (cnt_count == WIDTH'(1)) ? DONE : WAIT_REQ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dack     = (state_q == ACK);
    assign cnt_en   = (state_q == ACK);
    assign cnt_load = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign cnt_data = len_q;
    assign cnt_dir  = 1'b0;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed plus randomized bench for dma_xfer_ctrl with a behavioural counter
// and transaction-level expectations derived from transfer lengths.
module tb_dma_xfer_ctrl;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         nMR;
    logic         start;
    logic [W-1:0] cfg_len;
    logic         abort;
    logic         dreq;
    logic         dack;
    logic [W-1:0] cnt_data;
    logic         cnt_load;
    logic         cnt_dir;
    logic         cnt_en;
    logic [W-1:0] cnt_count = '0;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         irq;
    logic         irq_clr;

    int n_tests = 0;
    int n_fail  = 0;

    int   dack_cnt    = 0;
    int   done_cnt    = 0;
    int   load_cnt    = 0;
    int   b2b_viol    = 0;
    int   decode_viol = 0;
    logic prev_dack   = 1'b0;
    int   dack_vals[$];

    always #5 clk = ~clk;

    dma_xfer_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .nMR      (nMR),
        .start    (start),
        .cfg_len  (cfg_len),
        .abort    (abort),
        .dreq     (dreq),
        .dack     (dack),
        .cnt_data (cnt_data),
        .cnt_load (cnt_load),
        .cnt_dir  (cnt_dir),
        .cnt_en   (cnt_en),
        .cnt_count(cnt_count),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .irq      (irq),
        .irq_clr  (irq_clr)
    );

    // Behavioural up/down counter the sequencer drives.
    always @(posedge clk) begin
        if (cnt_load) cnt_count <= cnt_data;
        else if (cnt_en) cnt_count <= cnt_dir ? cnt_count + 1'b1 : cnt_count - 1'b1;
    end

    // Transaction monitor: counts pulses and records the count seen on each beat.
    always @(negedge clk) begin
        if (dack) begin
            dack_cnt <= dack_cnt + 1;
            dack_vals.push_back(int'(cnt_count));
        end
        if (done) done_cnt <= done_cnt + 1;
        if (cnt_load) load_cnt <= load_cnt + 1;
        if (dack && prev_dack) b2b_viol <= b2b_viol + 1;
        if ((dack !== cnt_en) || (cnt_dir !== 1'b0)) decode_viol <= decode_viol + 1;
        prev_dack <= dack;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] len);
        cfg_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        cfg_len = W'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("done_reached", done, 1);
    endtask

    function automatic int seq_errors(input int base, input int len);
        int err;
        err = 0;
        for (int i = 0; i < len; i++) begin
            if (base + i >= dack_vals.size()) err++;
            else if (dack_vals[base + i] != len - i) err++;
        end
        return err;
    endfunction

    initial begin
        int bd, bo, bl, bq, n, cyc;

        nMR = 1'b0; start = 1'b0; cfg_len = '0; abort = 1'b0;
        dreq = 1'b0; irq_clr = 1'b0;
        #22;
        chk("rst_busy", busy, 0);
        chk("rst_dack", dack, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_data", cnt_data, 0);
        chk("rst_dir", cnt_dir, 0);
        nMR = 1'b1;
        tick();

        // Length 3 with dreq held high.
        bd = dack_cnt; bo = done_cnt; bl = load_cnt; bq = dack_vals.size();
        dreq = 1'b1;
        do_start(3);
        chk("l3_load", cnt_load, 1);
        chk("l3_data", cnt_data, 3);
        chk("l3_busy", busy, 1);
        tick();
        chk("l3_wait_load", cnt_load, 0);
        chk("l3_cnt_loaded", cnt_count, 3);
        tick();
        chk("l3_first_dack", dack, 1);
        wait_done(50);
        tick();
        chk("l3_dacks", dack_cnt - bd, 3);
        chk("l3_seq", seq_errors(bq, 3), 0);
        chk("l3_loads", load_cnt - bl, 1);
        chk("l3_dones", done_cnt - bo, 1);
        chk("l3_cnt_end", cnt_count, 0);
        chk("l3_irq", irq, 1);
        chk("l3_aborted", aborted, 0);
        chk("l3_busy_end", busy, 0);
        chk("l3_b2b", b2b_viol, 0);
        dreq = 1'b0;

        // irq_clr in idle, then zero-length transfer.
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("clr_idle", irq, 0);
        bd = dack_cnt; bo = done_cnt; bl = load_cnt;
        dreq = 1'b1;
        do_start(0);
        chk("l0_done_now", done, 1);
        chk("l0_load", cnt_load, 0);
        tick();
        chk("l0_dacks", dack_cnt - bd, 0);
        chk("l0_loads", load_cnt - bl, 0);
        chk("l0_dones", done_cnt - bo, 1);
        chk("l0_irq", irq, 1);
        chk("l0_busy", busy, 0);

        // Length 5 aborted after the second beat.
        bd = dack_cnt; bo = done_cnt;
        do_start(5);
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            tick();
            cyc++;
            if (dack === 1'b1) n++;
        end
        chk("ab_two_beats_seen", n, 2);
        abort = 1'b1;
        wait_done(20);
        tick();
        abort = 1'b0;
        chk("ab_dacks", dack_cnt - bd, 2);
        chk("ab_dones", done_cnt - bo, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_cnt_hold", cnt_count, 3);
        chk("ab_busy", busy, 0);

        // Asynchronous reset while in a beat.
        bo = done_cnt;
        do_start(3);
        chk("rs_aborted_cleared", aborted, 0);
        tick();
        tick();
        chk("rs_in_ack", dack, 1);
        nMR = 1'b0;
        #1;
        chk("rs_dack_async", dack, 0);
        chk("rs_en_async", cnt_en, 0);
        chk("rs_busy_async", busy, 0);
        chk("rs_irq_async", irq, 0);
        #2;
        nMR = 1'b1;
        tick();
        tick();
        chk("rs_busy_after", busy, 0);
        chk("rs_irq_after", irq, 0);
        chk("rs_aborted_after", aborted, 0);
        chk("rs_no_done", done_cnt - bo, 0);

        // Full-scale length with random dreq and a start while busy.
        bd = dack_cnt; bo = done_cnt; bl = load_cnt; bq = dack_vals.size();
        dreq = 1'b0;
        do_start(10'd1023);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            dreq = 1'($urandom_range(0, 1));
            if (cyc == 40) begin
                start = 1'b1;
                cfg_len = 10'd7;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("fs_done_reached", done, 1);
        tick();
        chk("fs_dacks", dack_cnt - bd, 1023);
        chk("fs_seq", seq_errors(bq, 1023), 0);
        chk("fs_cnt_end", cnt_count, 0);
        chk("fs_loads", load_cnt - bl, 1);
        chk("fs_dones", done_cnt - bo, 1);
        chk("fs_aborted", aborted, 0);
        chk("fs_b2b", b2b_viol, 0);

        // irq_clr coincident with DONE: set wins.
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("ic_pre_clear", irq, 0);
        dreq = 1'b1;
        do_start(2);
        wait_done(30);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("ic_set_wins", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("ic_later_clear", irq, 0);
        chk("decode_consistent", decode_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
